multi_mux_arb: RTL and testbench

Parametrised, registered N-channel W-bit multiplexer with valid/ready handshaking and per-cycle arbitration. It replaces the fixed 4-bit two-input select mux wherever several producers share one consumer. It picks one channel per cycle by round-robin or fixed priority, with an optional forced-select override. The chosen word, and the index of the channel it came from, are held in an output register.

---
 rtl/multi_mux_arb.sv | 117 +++++++++++
 tb/tb_multi_mux_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mux_arb.sv
// multi_mux_arb: registered N-channel W-bit multiplexer with valid/ready handshaking,
// round-robin or fixed-priority arbitration and a forced-select override.
module multi_mux_arb #(
  parameter int W    = 4,
  parameter int N    = 2,
  parameter int MODE = 0,
  localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           force_en,
  input  logic [SW-1:0]  force_sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0]   elig;
  logic [2*N-1:0] rot;
  logic           any_elig;
  logic [SW-1:0]  grant;
  logic [W-1:0]   grant_data;
  logic           load;
  logic           xfer;

  logic [W-1:0]   out_data_q,  out_data_d;
  logic [SW-1:0]  out_ch_q,    out_ch_d;
  logic           out_valid_q, out_valid_d;
  logic [SW-1:0]  ptr_q,       ptr_d;

  // An out-of-range force_sel matches no channel, so the mask is simply empty.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = in_valid[i] & (!force_en | (force_sel == SW'(i)));
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant    = '0;
    any_elig = 1'b0;
    rot      = {elig, elig} >> ptr_q;
    if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (elig[i]) begin
          grant    = SW'(i);
          any_elig = 1'b1;
        end
      end
    end else begin
      // rot[k] is channel (ptr+k) mod N; scanning down leaves the smallest offset winning.
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) begin
          grant    = (int'(ptr_q) + k >= N) ? SW'(int'(ptr_q) + k - N) : SW'(int'(ptr_q) + k);
          any_elig = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) grant_data = in_data[i*W +: W];
    end
  end

  assign load = !out_valid_q | out_ready;
  assign xfer = rst_n & load & any_elig;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer & (grant == SW'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (MODE == 0) begin
        ptr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_mux_arb.sv
// Bench for multi_mux_arb: four configurations (N=2 RR, N=4 RR, N=4 fixed priority,
// N=3 RR) checked against a queue of expected output words.
module tb_multi_mux_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] ch;
  } exp_t;

  exp_t sb[$];

  // u_a: N=2 round-robin
  logic [7:0]  a_in_data;
  logic [1:0]  a_in_valid, a_in_ready;
  logic        a_force_en, a_out_valid, a_out_ready;
  logic [0:0]  a_force_sel, a_out_ch;
  logic [3:0]  a_out_data;
  // u_b: N=4 round-robin
  logic [15:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic        b_force_en, b_out_valid, b_out_ready;
  logic [1:0]  b_force_sel, b_out_ch;
  logic [3:0]  b_out_data;
  // u_c: N=4 fixed priority
  logic [15:0] c_in_data;
  logic [3:0]  c_in_valid, c_in_ready;
  logic        c_force_en, c_out_valid, c_out_ready;
  logic [1:0]  c_force_sel, c_out_ch;
  logic [3:0]  c_out_data;
  // u_d: N=3 round-robin
  logic [11:0] d_in_data;
  logic [2:0]  d_in_valid, d_in_ready;
  logic        d_force_en, d_out_valid, d_out_ready;
  logic [1:0]  d_force_sel, d_out_ch;
  logic [3:0]  d_out_data;

  multi_mux_arb #(.W(4), .N(2), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .force_en(a_force_en), .force_sel(a_force_sel),
    .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready));

  multi_mux_arb #(.W(4), .N(4), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .force_en(b_force_en), .force_sel(b_force_sel),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready));

  multi_mux_arb #(.W(4), .N(4), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .force_en(c_force_en), .force_sel(c_force_sel),
    .out_data(c_out_data), .out_ch(c_out_ch), .out_valid(c_out_valid), .out_ready(c_out_ready));

  multi_mux_arb #(.W(4), .N(3), .MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_data(d_in_data), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .force_en(d_force_en), .force_sel(d_force_sel),
    .out_data(d_out_data), .out_ch(d_out_ch), .out_valid(d_out_valid), .out_ready(d_out_ready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    a_in_data = 8'h21; a_in_valid = 2'b11; a_out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (a_in_ready !== 2'b00 || a_out_valid !== 1'b0 || a_out_data !== 4'h0 || a_out_ch !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%h out_ch=%0d, want 00/0/0/0",
                 c, a_in_ready, a_out_valid, a_out_data, a_out_ch);
      end
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (a_in_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant: in_ready=%b, want 01", a_in_ready);
    end
    sb.push_back('{data: 4'h1, ch: 2'd0});
    tick();
    e = sb.pop_front();
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== e.data || {1'b0, a_out_ch} !== e.ch) begin
      n_fail++;
      $display("FAIL reset_first_word: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
               a_out_valid, a_out_data, a_out_ch, e.data, e.ch);
    end
    a_in_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    exp_t e;
    b_in_data = 16'hDCBA; b_in_valid = 4'hF; b_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_tests++;
      if (b_in_ready !== (4'b0001 << (k % 4))) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: in_ready=%b, want %b", k, b_in_ready, 4'b0001 << (k % 4));
      end
      sb.push_back('{data: 4'(4'hA + k % 4), ch: 2'(k % 4)});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (b_out_valid !== 1'b1 || b_out_data !== e.data || b_out_ch !== e.ch) begin
        n_fail++;
        $display("FAIL rr_word[%0d]: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
                 k, b_out_valid, b_out_data, b_out_ch, e.data, e.ch);
      end
    end
    b_in_valid = 4'h0;
    tick();
    n_tests++;
    if (b_out_valid !== 1'b0 || b_out_data !== 4'hD || b_out_ch !== 2'd3) begin
      n_fail++;
      $display("FAIL rr_idle: v=%b d=%h ch=%0d, want v=0 d=d ch=3", b_out_valid, b_out_data, b_out_ch);
    end
  endtask

  task automatic test_fixed_priority();
    exp_t e;
    logic [3:0] pv [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0001};
    int         pch [6] = '{1, 1, 1, 3, 3, 0};
    c_in_data = 16'h4321; c_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_in_valid = pv[i];
      #1;
      n_tests++;
      if (c_in_ready !== (4'b0001 << pch[i])) begin
        n_fail++;
        $display("FAIL prio_ready[%0d]: in_ready=%b, want %b", i, c_in_ready, 4'b0001 << pch[i]);
      end
      sb.push_back('{data: 4'(pch[i] + 1), ch: 2'(pch[i])});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (c_out_valid !== 1'b1 || c_out_data !== e.data || c_out_ch !== e.ch) begin
        n_fail++;
        $display("FAIL prio_word[%0d]: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
                 i, c_out_valid, c_out_data, c_out_ch, e.data, e.ch);
      end
    end
    c_in_valid = 4'h0;
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    b_in_data = 16'hE395; b_in_valid = 4'b0001; b_out_ready = 1'b1;
    sb.push_back('{data: 4'h5, ch: 2'd0});
    tick();
    e = sb.pop_front();
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_data !== e.data || b_out_ch !== e.ch) begin
      n_fail++;
      $display("FAIL bp_load: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
               b_out_valid, b_out_data, b_out_ch, e.data, e.ch);
    end
    b_out_ready = 1'b0; b_in_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (b_in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: in_ready=%b, want 0000", c, b_in_ready);
      end
      tick();
      n_tests++;
      if (b_out_valid !== 1'b1 || b_out_data !== 4'h5 || b_out_ch !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h ch=%0d, want v=1 d=5 ch=0",
                 c, b_out_valid, b_out_data, b_out_ch);
      end
    end
    b_out_ready = 1'b1;
    #1;
    n_tests++;
    if (b_in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_ready: in_ready=%b, want 0010", b_in_ready);
    end
    sb.push_back('{data: 4'h9, ch: 2'd1});
    tick();
    e = sb.pop_front();
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_data !== e.data || b_out_ch !== e.ch) begin
      n_fail++;
      $display("FAIL bp_release_word: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
               b_out_valid, b_out_data, b_out_ch, e.data, e.ch);
    end
    b_in_valid = 4'h0;
    tick();
  endtask

  task automatic test_force();
    exp_t e;
    a_in_data = 8'h76; a_in_valid = 2'b11; a_out_ready = 1'b1;
    a_force_en = 1'b1; a_force_sel = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (a_in_ready !== 2'b10) begin
        n_fail++;
        $display("FAIL force_ready[%0d]: in_ready=%b, want 10", c, a_in_ready);
      end
      sb.push_back('{data: 4'h7, ch: 2'd1});
      tick();
      e = sb.pop_front();
      n_tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== e.data || {1'b0, a_out_ch} !== e.ch) begin
        n_fail++;
        $display("FAIL force_word[%0d]: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
                 c, a_out_valid, a_out_data, a_out_ch, e.data, e.ch);
      end
    end
    a_force_sel = 1'b0;
    #1;
    n_tests++;
    if (a_in_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL force_sel_change: in_ready=%b, want 01", a_in_ready);
    end
    a_force_en = 1'b0;
    #1;
    n_tests++;
    if (a_in_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL force_ptr_after: in_ready=%b, want 01", a_in_ready);
    end
    sb.push_back('{data: 4'h6, ch: 2'd0});
    tick();
    e = sb.pop_front();
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== e.data || {1'b0, a_out_ch} !== e.ch) begin
      n_fail++;
      $display("FAIL force_unforced_word: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
               a_out_valid, a_out_data, a_out_ch, e.data, e.ch);
    end
    #1;
    n_tests++;
    if (a_in_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL force_rr_resume: in_ready=%b, want 10", a_in_ready);
    end
    a_in_valid = 2'b00;
    tick();
  endtask

  task automatic test_force_oob();
    exp_t e;
    d_in_data = 12'hCBA; d_in_valid = 3'b111; d_out_ready = 1'b1;
    d_force_en = 1'b1; d_force_sel = 2'd2;
    #1;
    n_tests++;
    if (d_in_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL oob_sel2_ready: in_ready=%b, want 100", d_in_ready);
    end
    sb.push_back('{data: 4'hC, ch: 2'd2});
    tick();
    e = sb.pop_front();
    n_tests++;
    if (d_out_valid !== 1'b1 || d_out_data !== e.data || d_out_ch !== e.ch) begin
      n_fail++;
      $display("FAIL oob_sel2_word: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
               d_out_valid, d_out_data, d_out_ch, e.data, e.ch);
    end
    d_force_sel = 2'd3;
    #1;
    n_tests++;
    if (d_in_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL oob_sel3_ready: in_ready=%b, want 000", d_in_ready);
    end
    tick();
    n_tests++;
    if (d_out_valid !== 1'b0 || d_out_data !== 4'hC || d_out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL oob_sel3_out: v=%b d=%h ch=%0d, want v=0 d=c ch=2",
               d_out_valid, d_out_data, d_out_ch);
    end
    d_force_en = 1'b0; d_in_valid = 3'b000;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    b_in_data = 16'h4321; b_in_valid = 4'b0100; b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0; b_in_valid = 4'hF;
    tick();
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_data !== 4'h3 || b_out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_held: v=%b d=%h ch=%0d, want v=1 d=3 ch=2", b_out_valid, b_out_data, b_out_ch);
    end
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (b_out_valid !== 1'b0 || b_out_data !== 4'h0 || b_out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b d=%h ch=%0d, want v=0 d=0 ch=0", b_out_valid, b_out_data, b_out_ch);
    end
    b_out_ready = 1'b1;
    #1;
    n_tests++;
    if (b_in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_ready: in_ready=%b, want 0000", b_in_ready);
    end
    tick();
    n_tests++;
    if (b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_partial: v=%b, want 0", b_out_valid);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (b_in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_ptr_cleared: in_ready=%b, want 0001", b_in_ready);
    end
    sb.push_back('{data: 4'h1, ch: 2'd0});
    tick();
    e = sb.pop_front();
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_data !== e.data || b_out_ch !== e.ch) begin
      n_fail++;
      $display("FAIL mid_first_word: v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
               b_out_valid, b_out_data, b_out_ch, e.data, e.ch);
    end
    b_in_valid = 4'h0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_force_en = 1'b0; a_force_sel = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = '0; b_force_en = 1'b0; b_force_sel = '0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = '0; c_force_en = 1'b0; c_force_sel = '0; c_out_ready = 1'b1;
    d_in_data = '0; d_in_valid = '0; d_force_en = 1'b0; d_force_sel = '0; d_out_ready = 1'b1;

    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_force();
    test_force_oob();
    test_reset_midstream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
